// File: rtl/addsub_pkg.sv
// Shared types for the chunked add/sub datapath: controller states and op encoding.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/chunked_add_sub_if.sv
// Operand/result handshake bundle for chunked_add_sub; slave is the arithmetic block side.
interface chunked_add_sub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );
endinterface

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple adder of full adders; also exposes the carry into its MSB.
module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);
    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[CHUNK];
    assign cmsb = c[CHUNK-1];
endmodule

// File: rtl/chunked_add_sub.sv
// Multi-cycle WIDTH-bit add/sub, CHUNK bits per cycle through one shared ripple adder.
// Optional macro ADDSUB_SAT_EN replaces wrapped results with signed saturation on overflow.
module chunked_add_sub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    chunked_add_sub_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
    logic [WIDTH-1:0] sum_next, sum_final;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic             cout_reg, ovf_reg, zero_reg;
    logic             accept, last;

    logic [CHUNK-1:0] ch_sum;
    logic             ch_cout, ch_cmsb;
    logic             ovf_next;

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (a_reg[idx*CHUNK +: CHUNK]),
        .b    (b_reg[idx*CHUNK +: CHUNK]),
        .cin  (carry),
        .sum  (ch_sum),
        .cout (ch_cout),
        .cmsb (ch_cmsb)
    );

`ifdef ADDSUB_SAT_EN
    function automatic logic [WIDTH-1:0] sat_value(input logic neg);
        sat_value = neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction
`endif

    assign accept   = bus.in_valid && (state == IDLE);
    assign last     = (idx == LAST_IDX);
    // Only meaningful on the last chunk, where the chunk MSB is the word MSB.
    assign ovf_next = ch_cmsb ^ ch_cout;

    always_comb begin
        sum_next = sum_reg;
        sum_next[idx*CHUNK +: CHUNK] = ch_sum;
`ifdef ADDSUB_SAT_EN
        sum_final = ovf_next ? sat_value(a_reg[WIDTH-1]) : sum_next;
`else
        sum_final = sum_next;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = BUSY;
            BUSY:    if (last) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.out_sum   = sum_reg;
        bus.out_cout  = cout_reg;
        bus.out_ovf   = ovf_reg;
        bus.out_zero  = zero_reg;
    end

    // Capture stage: subtract becomes A + ~B with an initial carry of one.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
            zero_reg <= 1'b0;
        end else if (accept) begin
            a_reg <= bus.in_a;
            b_reg <= bus.in_b ^ {WIDTH{bus.in_sub}};
            carry <= (bus.in_sub == OP_SUB);
            idx   <= '0;
        end else if (state == BUSY) begin
            // Chunk stage: one slice per cycle, carry held between slices.
            carry <= ch_cout;
            if (last) begin
                idx      <= '0;
                sum_reg  <= sum_final;
                cout_reg <= ch_cout;
                ovf_reg  <= ovf_next;
                zero_reg <= (sum_final == '0);
            end else begin
                idx     <= idx + 1'b1;
                sum_reg <= sum_next;
            end
        end
    end
endmodule
